// File: rtl/lcd_write_byte.sv
// Byte-write responder: sends one command/data byte to a 4-bit character LCD as two E-strobed nibbles.
// Optional macro LCD_LONG_CMD_WAIT_EN stretches the post-byte wait for clear (8'h01) and home (8'h02) commands.
module lcd_write_byte #(
    parameter int SETUP_CYC      = 2,
    parameter int E_PULSE_CYC    = 12,
    parameter int NIBBLE_GAP_CYC = 50,
    parameter int CMD_WAIT_CYC   = 2000,
    parameter int CNT_W          = 17
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       doWriteByte,
    input  logic [7:0] dataIn,
    input  logic       rsIn,
    output logic       writeByteReady,
    output logic       writeByteDone,
    output logic [3:0] LCD_DB,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW
);

    typedef enum logic [2:0] {
        IDLE, UP_SETUP, UP_E, UP_GAP, LO_SETUP, LO_E, LO_WAIT, DONE
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_LAST     = CNT_W'(E_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(NIBBLE_GAP_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             rs_q, rs_d;
    logic [CNT_W-1:0] wait_last;
    logic [CNT_W-1:0] last;
    state_t           nxt;

`ifdef LCD_LONG_CMD_WAIT_EN
    localparam int LONG_CMD_WAIT_CYC = 82000;
    logic long_cmd;
    assign long_cmd  = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02);
    assign wait_last = long_cmd ? CNT_W'(LONG_CMD_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
`else
    assign wait_last = CNT_W'(CMD_WAIT_CYC - 1);
`endif

    // NOTE: non-blocking assignments here so every register updates from pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            byte_q  <= '0;
            rs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            rs_q    <= rs_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        byte_d  = byte_q;
        rs_d    = rs_q;
        last    = '0;
        nxt     = state_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (doWriteByte) begin
                    byte_d  = dataIn;
                    rs_d    = rsIn;
                    state_d = UP_SETUP;
                end
            end
            UP_SETUP: begin last = SETUP_LAST; nxt = UP_E;     end
            UP_E:     begin last = E_LAST;     nxt = UP_GAP;   end
            UP_GAP:   begin last = GAP_LAST;   nxt = LO_SETUP; end
            LO_SETUP: begin last = SETUP_LAST; nxt = LO_E;     end
            LO_E:     begin last = E_LAST;     nxt = LO_WAIT;  end
            LO_WAIT:  begin last = wait_last;  nxt = DONE;     end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Timed states leave on their last count; the counter restarts on every entry.
        if (state_q != IDLE && state_q != DONE && cnt_q == last) begin
            cnt_d   = '0;
            state_d = nxt;
        end
    end

    always_comb begin
        writeByteReady = 1'b0;
        writeByteDone  = 1'b0;
        LCD_DB         = 4'h0;
        LCD_E          = 1'b0;
        LCD_RS         = rs_q;
        case (state_q)
            IDLE: begin
                writeByteReady = 1'b1;
                LCD_RS         = 1'b0;
            end
            UP_SETUP, UP_GAP: LCD_DB = byte_q[7:4];
            UP_E: begin
                LCD_DB = byte_q[7:4];
                LCD_E  = 1'b1;
            end
            LO_SETUP, LO_WAIT: LCD_DB = byte_q[3:0];
            LO_E: begin
                LCD_DB = byte_q[3:0];
                LCD_E  = 1'b1;
            end
            DONE:    writeByteDone = 1'b1;
            default: LCD_DB = 4'h0;
        endcase
    end

    assign LCD_RW = 1'b0;

endmodule
